// File: rtl/lf_edge_pkg.sv
// Shared types and constants for the LF edge controller and its interval FIFO.
package lf_edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOST = 2'd3
  } state_t;

  localparam int REC_W   = 16;
  localparam int WIDTH_W = 15;
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = 15'h7FFF;

  // Signal swing of the min/max tracker; an inverted pair (min > max) counts as no swing.
  function automatic logic [7:0] swing_of(input logic [7:0] max_v, input logic [7:0] min_v);
    logic [8:0] diff;
    diff = {1'b0, max_v} - {1'b0, min_v};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

endpackage

// File: rtl/lf_interval_fifo.sv
// Two-entry record FIFO between the edge timestamper and the downstream decoder.
// A push into a full FIFO is accepted only when the head leaves in the same cycle;
// otherwise it is discarded and reported on drop.
module lf_interval_fifo
  import lf_edge_pkg::*;
#(
  parameter int W = REC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         pop_ok;
  logic         push_ok;

  assign full    = (count_reg == 2'd2);
  assign valid   = (count_reg != 2'd0);
  assign data    = mem_reg[rd_ptr_reg];
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  // Storage slots: each entry only loads when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/lf_edge_ctrl.sv
// Sequencer for lf_edge_detect: calibrates until the tracker shows enough swing,
// then timestamps detector edges into level/width records and watches for carrier loss.
module lf_edge_ctrl
  import lf_edge_pkg::*;
#(
  parameter int         CAL_CYCLES        = 1024,
  parameter int         TIMEOUT           = 4096,
  parameter logic [7:0] DEFAULT_THRESHOLD = 8'd127
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        cfg_threshold,
  input  logic [7:0]        cfg_min_swing,
  input  logic [7:0]        det_max,
  input  logic [7:0]        det_min,
  input  logic              edge_state,
  input  logic              edge_toggle,
  output logic [7:0]        lf_ed_threshold,
  output logic [1:0]        state,
  output logic              locked,
  output logic [REC_W-1:0]  interval_data,
  output logic              interval_valid,
  input  logic              interval_ready,
  output logic              overflow,
  output logic              lost
);

  localparam int                  CAL_W     = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
  localparam logic [CAL_W-1:0]    CAL_LAST  = CAL_W'(CAL_CYCLES - 1);
  localparam logic [WIDTH_W-1:0]  TIMEOUT_W = WIDTH_W'(TIMEOUT);

  state_t               state_reg;
  state_t               state_next;
  logic [CAL_W-1:0]     cal_cnt_reg;
  logic [WIDTH_W-1:0]   width_reg;
  logic                 first_edge_reg;
  logic [7:0]           thr_reg;
  logic                 overflow_reg;
  logic                 lost_reg;

  logic                 cal_done;
  logic                 swing_ok;
  logic                 timeout_hit;
  logic                 push;
  logic                 drop;
  logic                 full;
  logic [REC_W-1:0]     rec;

  assign cal_done    = (state_reg == ST_CAL) && (cal_cnt_reg == CAL_LAST);
  assign swing_ok    = (swing_of(det_max, det_min) >= cfg_min_swing);
  // A toggle in the same cycle always wins over the timeout.
  assign timeout_hit = (state_reg == ST_RUN) && !edge_toggle && (width_reg >= TIMEOUT_W);
  // The first edge after lock only marks a reference point; it closes no interval.
  assign push        = (state_reg == ST_RUN) && edge_toggle && !first_edge_reg;
  // edge_state is the new level, so the finished interval had the opposite level.
  assign rec         = {~edge_state, width_reg};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; dropping enable parks the controller from any state.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_CAL;
        ST_CAL:  if (cal_done && swing_ok) state_next = ST_RUN;
        ST_RUN:  if (timeout_hit) state_next = ST_LOST;
        ST_LOST: state_next = ST_CAL;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    locked          = (state_reg == ST_RUN);
    lf_ed_threshold = (state_reg == ST_RUN) ? thr_reg : DEFAULT_THRESHOLD;
  end

  // Calibration period counter: restarts on every CAL entry and after each failed check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_cnt_reg <= '0;
    end else if (state_next == ST_CAL && state_reg != ST_CAL) begin
      cal_cnt_reg <= '0;
    end else if (state_reg == ST_CAL) begin
      cal_cnt_reg <= cal_done ? '0 : cal_cnt_reg + 1'b1;
    end
  end

  // Interval width counter, first-edge marker and threshold latched on lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_reg      <= '0;
      first_edge_reg <= 1'b0;
      thr_reg        <= DEFAULT_THRESHOLD;
    end else if (state_reg == ST_CAL && state_next == ST_RUN) begin
      width_reg      <= '0;
      first_edge_reg <= 1'b1;
      thr_reg        <= cfg_threshold;
    end else if (state_reg == ST_RUN) begin
      if (edge_toggle) begin
        width_reg      <= WIDTH_W'(1);
        first_edge_reg <= 1'b0;
      end else if (width_reg != WIDTH_MAX) begin
        width_reg <= width_reg + 1'b1;
      end
    end
  end

  // Sticky status flags; a fresh start from IDLE clears them, recovery from LOST does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      lost_reg     <= 1'b0;
    end else if (state_reg == ST_IDLE && state_next == ST_CAL) begin
      overflow_reg <= 1'b0;
      lost_reg     <= 1'b0;
    end else begin
      if (drop)                  overflow_reg <= 1'b1;
      if (state_next == ST_LOST) lost_reg     <= 1'b1;
    end
  end

  assign state    = state_reg;
  assign overflow = overflow_reg;
  assign lost     = lost_reg;

  lf_interval_fifo #(.W(REC_W)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (rec),
    .pop       (interval_valid & interval_ready),
    .valid     (interval_valid),
    .data      (interval_data),
    .full      (full),
    .drop      (drop)
  );

endmodule

// File: tb/tb_lf_edge_ctrl.sv
// Directed bench for lf_edge_ctrl: expected records go into a queue as edges are
// issued, and a monitor process pops and compares each record the DUT hands over.
module tb_lf_edge_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  cfg_threshold;
  logic [7:0]  cfg_min_swing;
  logic [7:0]  det_max;
  logic [7:0]  det_min;
  logic        edge_state;
  logic        edge_toggle;
  logic        interval_ready;
  logic [7:0]  lf_ed_threshold;
  logic [1:0]  state;
  logic        locked;
  logic [15:0] interval_data;
  logic        interval_valid;
  logic        overflow;
  logic        lost;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  lf_edge_ctrl #(
    .CAL_CYCLES        (16),
    .TIMEOUT           (64),
    .DEFAULT_THRESHOLD (8'd127)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .cfg_threshold   (cfg_threshold),
    .cfg_min_swing   (cfg_min_swing),
    .det_max         (det_max),
    .det_min         (det_min),
    .edge_state      (edge_state),
    .edge_toggle     (edge_toggle),
    .lf_ed_threshold (lf_ed_threshold),
    .state           (state),
    .locked          (locked),
    .interval_data   (interval_data),
    .interval_valid  (interval_valid),
    .interval_ready  (interval_ready),
    .overflow        (overflow),
    .lost            (lost)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle detector edge with the new level.
  task automatic pulse(input logic lvl);
    edge_state  = lvl;
    edge_toggle = 1'b1;
    tick();
    edge_toggle = 1'b0;
  endtask

  // Edge issued 'gap' clocks after the previous one, so the closed interval has width 'gap'.
  task automatic gap_pulse(input int gap, input logic lvl);
    repeat (gap - 1) tick();
    pulse(lvl);
  endtask

  // Counts clocks until the DUT leaves state 'st', bounded so a stuck DUT cannot hang the run.
  task automatic wait_leave(input logic [1:0] st, output int n);
    n = 0;
    while (state == st && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_thr"}, lf_ed_threshold, 127);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_valid"}, interval_valid, 0);
    chk({tag, "_data"}, interval_data, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_lost"}, lost, 0);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    enable         = 1'b0;
    cfg_threshold  = 8'd90;
    cfg_min_swing  = 8'd100;
    det_max        = 8'd200;
    det_min        = 8'd50;
    edge_state     = 1'b0;
    edge_toggle    = 1'b0;
    interval_ready = 1'b1;

    fork
      // Monitor: every handshake must match the oldest expected record.
      forever begin
        @(negedge clk);
        if (!reset && interval_valid === 1'b1 && interval_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got 0x%04h expected none at %0t", interval_data, $time);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            $display("record got 0x%04h expected 0x%04h at %0t", interval_data, e, $time);
            chk("record", interval_data, e);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values.
    tick();
    chk_reset_outputs("reset");

    // First lock: swing 150 >= 100 after one 16-clock calibration period.
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    chk("cal_entry_state", state, 1);
    chk("cal_thr", lf_ed_threshold, 127);
    wait_leave(2'd1, n);
    chk("cal_len", n, 16);
    chk("lock_state", state, 2);
    chk("lock_thr", lf_ed_threshold, 90);
    chk("lock_locked", locked, 1);

    // Toggles 20 and 30 clocks apart; the first edge is discarded.
    pulse(1'b1);
    chk("first_edge_no_rec", interval_valid, 0);
    exp_q.push_back(16'h8014);
    gap_pulse(20, 1'b0);
    chk("rec1_latency", interval_valid, 1);
    exp_q.push_back(16'h001E);
    gap_pulse(30, 1'b1);
    chk("rec2_latency", interval_valid, 1);

    // Overflow: consumer stalls, three records arrive, the third is dropped.
    tick();                        // 0x001E drains on this edge
    interval_ready = 1'b0;
    exp_q.push_back(16'h8005);
    gap_pulse(4, 1'b0);            // plus the drain clock above: width 5
    exp_q.push_back(16'h0006);
    gap_pulse(6, 1'b1);
    chk("full_no_overflow", overflow, 0);
    gap_pulse(7, 1'b0);            // 0x8007 is dropped
    chk("overflow_set", overflow, 1);
    chk("head_stable", interval_data, 16'h8005);
    interval_ready = 1'b1;
    wait_leave(2'd2, n);           // no edges now: counts from the dropped toggle to LOST
    chk("timeout_len", n, 64);
    chk("lost_state", state, 3);
    chk("lost_flag", lost, 1);
    chk("lost_thr", lf_ed_threshold, 127);
    chk("lost_unlocked", locked, 0);
    chk("drained", interval_valid, 0);
    chk("overflow_sticky", overflow, 1);
    tick();
    chk("lost_to_cal", state, 1);
    chk("lost_kept", lost, 1);

    // Too little swing (40) for three periods, then enough.
    det_max       = 8'd90;
    cfg_threshold = 8'd77;
    repeat (48) tick();
    chk("low_swing_state", state, 1);
    chk("low_swing_thr", lf_ed_threshold, 127);
    det_max = 8'd200;
    wait_leave(2'd1, n);
    chk("relock_len", n, 16);
    chk("relock_thr", lf_ed_threshold, 77);
    cfg_threshold = 8'd33;
    tick();
    chk("thr_latched", lf_ed_threshold, 77);

    // Toggle coinciding with width == TIMEOUT: record pushed, stays in RUN.
    pulse(1'b1);
    exp_q.push_back(16'h8040);
    gap_pulse(64, 1'b0);
    chk("coincide_state", state, 2);
    chk("coincide_valid", interval_valid, 1);
    tick();
    chk("coincide_still_run", state, 2);

    // Disable -> IDLE; re-enable clears the sticky flags.
    enable = 1'b0;
    tick();
    chk("idle_state", state, 0);
    chk("idle_thr", lf_ed_threshold, 127);
    enable = 1'b1;
    tick();
    chk("reenable_state", state, 1);
    chk("reenable_overflow", overflow, 0);
    chk("reenable_lost", lost, 0);

    // Asynchronous reset while in RUN with a full FIFO.
    wait_leave(2'd1, n);
    chk("lock3_len", n, 16);
    interval_ready = 1'b0;
    pulse(1'b1);
    gap_pulse(3, 1'b0);
    gap_pulse(3, 1'b1);
    gap_pulse(3, 1'b0);
    chk("pre_reset_overflow", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    reset          = 1'b0;
    interval_ready = 1'b1;
    tick();
    chk("post_reset_cal", state, 1);
    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
